// File: rtl/uart_tx_ctrl.sv
// UART transmit-path controller: baud strobe generation, CTS auto-flow gating,
// host/DMA arbitration onto the TX FIFO push port, and THRE/TEMT status.
module uart_tx_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic [15:0]      dl,
  input  logic             dl_we,
  input  logic             afe,
  input  logic             cts_n,
  input  logic [2:0]       tx_state,
  input  logic [CNT_W-1:0] tf_count,
  input  logic             host_we,
  input  logic [7:0]       host_dat,
  input  logic             dma_req,
  input  logic [7:0]       dma_dat,
  output logic             dma_ack,
  output logic             tf_push,
  output logic [7:0]       tf_dat,
  output logic             enable,
  output logic             thre,
  output logic             temt,
  output logic             thre_int,
  output logic             tx_stalled
);

  localparam logic [CNT_W:0] DEPTH = (CNT_W+1)'(FIFO_DEPTH);

  logic [15:0]    bc;
  logic           tick;
  logic           cts_meta;
  logic           cts_sync;
  logic           cts_hold;
  logic           tx_idle;
  logic [CNT_W:0] fill;
  logic           grant;
  logic           push_next;
  logic           thre_next;

  // Baud down-counter; reloads from dl on a divisor write or on terminal count.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bc <= '0;
    end else if (dl_we || bc == 16'd1) begin
      bc <= dl;
    end else if (bc != 16'd0) begin
      bc <= bc - 16'd1;
    end
  end

  assign tick = (bc == 16'd1) && !dl_we;

  // Both flops reset to 1 so flow control starts in the "CTS deasserted" state.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cts_meta <= 1'b1;
      cts_sync <= 1'b1;
    end else begin
      cts_meta <= cts_n;
      cts_sync <= cts_meta;
    end
  end

  assign cts_hold = afe & cts_sync;
  assign tx_idle  = (tx_state == 3'd0);

  // Fill includes the push already in flight so the FIFO is never overfilled by DMA.
  assign fill      = {1'b0, tf_count} + {{CNT_W{1'b0}}, tf_push};
  assign grant     = !host_we && dma_req && !dma_ack && (fill < DEPTH);
  assign push_next = host_we | grant;
  assign thre_next = (tf_count == '0) && !tf_push && !push_next;

  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      enable     <= 1'b0;
      tf_push    <= 1'b0;
      tf_dat     <= 8'h00;
      dma_ack    <= 1'b0;
      thre       <= 1'b1;
      temt       <= 1'b1;
      thre_int   <= 1'b0;
      tx_stalled <= 1'b0;
    end else begin
      enable     <= tick & ~(cts_hold & tx_idle);
      tf_push    <= push_next;
      dma_ack    <= grant;
      if (host_we) begin
        tf_dat <= host_dat;
      end else if (grant) begin
        tf_dat <= dma_dat;
      end
      thre       <= thre_next;
      temt       <= thre_next & tx_idle;
      thre_int   <= thre_next & ~thre;
      tx_stalled <= cts_hold & tx_idle & (tf_count != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed self-checking bench for uart_tx_ctrl: baud, CTS gating, arbitration,
// FIFO-full boundary, status flags and mid-operation reset.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       wb_rst_i;
  logic [15:0] dl;
  logic       dl_we;
  logic       afe;
  logic       cts_n;
  logic [2:0] tx_state;
  logic [4:0] tf_count;
  logic       host_we;
  logic [7:0] host_dat;
  logic       dma_req;
  logic [7:0] dma_dat;
  logic       dma_ack;
  logic       tf_push;
  logic [7:0] tf_dat;
  logic       enable;
  logic       thre;
  logic       temt;
  logic       thre_int;
  logic       tx_stalled;

  int pass_cnt = 0;
  int total_cnt = 0;

  uart_tx_ctrl #(.FIFO_DEPTH(16), .CNT_W(5)) dut (
    .clk(clk), .wb_rst_i(wb_rst_i), .dl(dl), .dl_we(dl_we), .afe(afe),
    .cts_n(cts_n), .tx_state(tx_state), .tf_count(tf_count),
    .host_we(host_we), .host_dat(host_dat), .dma_req(dma_req),
    .dma_dat(dma_dat), .dma_ack(dma_ack), .tf_push(tf_push), .tf_dat(tf_dat),
    .enable(enable), .thre(thre), .temt(temt), .thre_int(thre_int),
    .tx_stalled(tx_stalled)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    dl = 16'd0; dl_we = 1'b0; afe = 1'b0; cts_n = 1'b0; tx_state = 3'd0;
    tf_count = 5'd0; host_we = 1'b0; host_dat = 8'h00; dma_req = 1'b0;
    dma_dat = 8'h00;
    #1;
    total_cnt++;
    if ({enable, tf_push, tf_dat, dma_ack, thre, temt, thre_int, tx_stalled} !== 15'b0_0_00000000_0_1_1_0_0)
      $display("FAIL reset_outputs: got en=%b push=%b dat=%h ack=%b thre=%b temt=%b int=%b stall=%b",
               enable, tf_push, tf_dat, dma_ack, thre, temt, thre_int, tx_stalled);
    else pass_cnt++;
    step();
    step();
    @(posedge clk);
    #3 wb_rst_i = 1'b0;
    step();
  endtask

  task automatic test_baud();
    int cnt;
    int first;
    dl = 16'd4; dl_we = 1'b1;
    step();
    dl_we = 1'b0;
    cnt = 0; first = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (enable) begin
        cnt++;
        if (first == 0) first = k;
      end
    end
    total_cnt++;
    if (first !== 4) $display("FAIL baud4_first: got cycle %0d, want 4", first);
    else pass_cnt++;
    total_cnt++;
    if (cnt !== 4) $display("FAIL baud4_count: got %0d pulses, want 4", cnt);
    else pass_cnt++;

    dl = 16'd0; dl_we = 1'b1;
    step();
    dl_we = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (enable) cnt++;
    end
    total_cnt++;
    if (cnt !== 0) $display("FAIL baud0_count: got %0d pulses, want 0", cnt);
    else pass_cnt++;

    dl = 16'd1; dl_we = 1'b1;
    step();
    dl_we = 1'b0;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (enable) cnt++;
    end
    total_cnt++;
    if (cnt !== 10) $display("FAIL baud1_count: got %0d pulses, want 10", cnt);
    else pass_cnt++;
  endtask

  task automatic test_cts_gate();
    afe = 1'b1; cts_n = 1'b1; tx_state = 3'd0; tf_count = 5'd3;
    for (int k = 0; k < 4; k++) step();
    total_cnt++;
    if (enable !== 1'b0) $display("FAIL cts_blocked_enable: got %b, want 0", enable);
    else pass_cnt++;
    total_cnt++;
    if (tx_stalled !== 1'b1) $display("FAIL cts_stalled_set: got %b, want 1", tx_stalled);
    else pass_cnt++;

    cts_n = 1'b0;
    step();
    step();
    total_cnt++;
    if (enable !== 1'b0) $display("FAIL cts_resume_early: got %b after 2 cycles, want 0", enable);
    else pass_cnt++;
    step();
    total_cnt++;
    if (enable !== 1'b1) $display("FAIL cts_resume_3cyc: got %b, want 1", enable);
    else pass_cnt++;
    total_cnt++;
    if (tx_stalled !== 1'b0) $display("FAIL cts_stalled_clear: got %b, want 0", tx_stalled);
    else pass_cnt++;
  endtask

  task automatic test_cts_midchar();
    int cnt;
    tx_state = 3'd2;
    step();
    cts_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (enable) cnt++;
    end
    total_cnt++;
    if (cnt !== 5) $display("FAIL midchar_ticks: got %0d of 5, want 5", cnt);
    else pass_cnt++;
    tx_state = 3'd0;
    step();
    total_cnt++;
    if (enable !== 1'b0) $display("FAIL midchar_stop_idle: got %b, want 0", enable);
    else pass_cnt++;
    cts_n = 1'b0; afe = 1'b0; tf_count = 5'd0;
    step();
    step();
  endtask

  task automatic test_arbitration();
    host_we = 1'b1; host_dat = 8'hA5; dma_req = 1'b1; dma_dat = 8'h3C;
    step();
    host_we = 1'b0;
    total_cnt++;
    if ({tf_push, tf_dat, dma_ack} !== {1'b1, 8'hA5, 1'b0})
      $display("FAIL arb_host_first: got push=%b dat=%h ack=%b, want 1 a5 0", tf_push, tf_dat, dma_ack);
    else pass_cnt++;
    total_cnt++;
    if (thre !== 1'b0) $display("FAIL arb_thre_low: got %b, want 0", thre);
    else pass_cnt++;
    step();
    dma_req = 1'b0;
    total_cnt++;
    if ({tf_push, tf_dat, dma_ack} !== {1'b1, 8'h3C, 1'b1})
      $display("FAIL arb_dma_second: got push=%b dat=%h ack=%b, want 1 3c 1", tf_push, tf_dat, dma_ack);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({tf_push, dma_ack} !== 2'b00)
      $display("FAIL arb_idle_after: got push=%b ack=%b, want 0 0", tf_push, dma_ack);
    else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    logic [3:0] acks;
    dma_req = 1'b1; dma_dat = 8'h10;
    for (int k = 0; k < 4; k++) begin
      step();
      pat[k] = tf_push;
      acks[k] = dma_ack;
      if (dma_ack) dma_dat = dma_dat + 8'h01;
    end
    dma_req = 1'b0;
    total_cnt++;
    if (pat !== 4'b0101) $display("FAIL b2b_push_pattern: got %b, want 0101", pat);
    else pass_cnt++;
    total_cnt++;
    if (acks !== 4'b0101) $display("FAIL b2b_ack_pattern: got %b, want 0101", acks);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_fifo_full();
    tf_count = 5'd15; host_we = 1'b1; host_dat = 8'h55; dma_req = 1'b1; dma_dat = 8'hE1;
    step();
    host_we = 1'b0;
    step();
    total_cnt++;
    if ({tf_push, dma_ack} !== 2'b00)
      $display("FAIL full_inflight_block: got push=%b ack=%b, want 0 0", tf_push, dma_ack);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({tf_push, tf_dat, dma_ack} !== {1'b1, 8'hE1, 1'b1})
      $display("FAIL full_last_grant: got push=%b dat=%h ack=%b, want 1 e1 1", tf_push, tf_dat, dma_ack);
    else pass_cnt++;
    tf_count = 5'd16; dma_dat = 8'hE2;
    step();
    step();
    total_cnt++;
    if ({tf_push, dma_ack} !== 2'b00)
      $display("FAIL full_at_16: got push=%b ack=%b, want 0 0", tf_push, dma_ack);
    else pass_cnt++;
    dma_req = 1'b0; tf_count = 5'd0;
    step();
    step();
  endtask

  task automatic test_status();
    tf_count = 5'd2; tx_state = 3'd2;
    step();
    total_cnt++;
    if ({thre, temt, thre_int} !== 3'b000)
      $display("FAIL status_busy: got thre=%b temt=%b int=%b, want 000", thre, temt, thre_int);
    else pass_cnt++;
    tf_count = 5'd0;
    step();
    total_cnt++;
    if ({thre, temt, thre_int} !== 3'b101)
      $display("FAIL status_drain: got thre=%b temt=%b int=%b, want 101", thre, temt, thre_int);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({thre, temt, thre_int} !== 3'b100)
      $display("FAIL status_int_pulse: got thre=%b temt=%b int=%b, want 100", thre, temt, thre_int);
    else pass_cnt++;
    tx_state = 3'd0;
    step();
    total_cnt++;
    if ({thre, temt, thre_int} !== 3'b110)
      $display("FAIL status_temt: got thre=%b temt=%b int=%b, want 110", thre, temt, thre_int);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    host_we = 1'b1; host_dat = 8'h9A;
    step();
    host_we = 1'b0; dma_req = 1'b1; dma_dat = 8'h77;
    wb_rst_i = 1'b1;
    #1;
    total_cnt++;
    if ({tf_push, dma_ack, thre} !== 3'b001)
      $display("FAIL midrst_async_clear: got push=%b ack=%b thre=%b, want 0 0 1", tf_push, dma_ack, thre);
    else pass_cnt++;
    #2 wb_rst_i = 1'b0;
    step();
    dma_req = 1'b0;
    total_cnt++;
    if ({tf_push, tf_dat, dma_ack} !== {1'b1, 8'h77, 1'b1})
      $display("FAIL midrst_rearb: got push=%b dat=%h ack=%b, want 1 77 1", tf_push, tf_dat, dma_ack);
    else pass_cnt++;
    step();
    total_cnt++;
    if (dma_ack !== 1'b0) $display("FAIL midrst_single_ack: got %b, want 0", dma_ack);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_baud();
    test_cts_gate();
    test_cts_midchar();
    test_arbitration();
    test_back_to_back();
    test_fifo_full();
    test_status();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Sequencing and arbitration controller for the UART transmit path. It sits in front of the transmitter/TX FIFO pair and does four jobs:
- generates the 16x baud `enable` strobe from the divisor latch;
- applies CTS auto-flow-control by holding `enable` only while the transmitter is idle;
- arbitrates the single FIFO push port between the host THR write path and a DMA byte source;
- produces the THRE/TEMT status and the THRE interrupt pulse.

## Interface
Parameters:
- FIFO_DEPTH, 16, TX FIFO capacity in bytes.
- CNT_W, 5, width of `tf_count`; must satisfy 2^CNT_W > FIFO_DEPTH.

Ports:
- clk  in  1  system clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- dl  in  16  divisor latch; baud tick period in clk cycles.
- dl_we  in  1  divisor written this cycle; reload the baud counter.
- afe  in  1  auto-flow-control enable.
- cts_n  in  1  modem CTS, active-low, asynchronous to clk.
- tx_state  in  3  transmitter state; 0 = idle.
- tf_count  in  CNT_W  TX FIFO occupancy.
- host_we  in  1  host THR write strobe, one cycle per byte.
- host_dat  in  8  host write data.
- dma_req  in  1  DMA byte available; held until acknowledged.
- dma_dat  in  8  DMA byte; stable while `dma_req` is high.
- dma_ack  out  1  one-cycle acknowledge; the DMA byte was taken.
- tf_push  out  1  FIFO push strobe.
- tf_dat  out  8  FIFO write data.
- enable  out  1  gated 16x baud strobe to the transmitter.
- thre  out  1  THR empty status.
- temt  out  1  transmitter fully empty.
- thre_int  out  1  one-cycle pulse on each THRE 0->1 transition.
- tx_stalled  out  1  a character is pending but blocked by CTS.

## Operation
- Baud counter: 16-bit down-counter `bc`.
  - On `dl_we`, or when `bc` == 1, load `bc` <= `dl`; otherwise `bc` decrements while nonzero.
  - Raw tick = (`bc` == 1) and not `dl_we`.
  - `dl` = 0: `bc` holds 0, no ticks.
  - `dl` = 1: tick every cycle.
- CTS synchronizer: two flops, both reset to 1. `cts_hold` = `afe` & `cts_sync` (CTS deasserted).
- Gating: `enable` = registered (tick & ~(`cts_hold` & `tx_state` == 0)).
  - Gating never suppresses ticks mid-character; once the transmitter leaves idle, all ticks pass.
  - The baud counter keeps running while `enable` is gated.
- Arbiter, evaluated each cycle; host has strict priority:
  - `host_we`=1: push `host_dat`. Host writes are never blocked. If the FIFO is full, overrun is the FIFO's responsibility.
  - else DMA grant when `dma_req` & ~`dma_ack` & (`tf_count` + `tf_push`) < FIFO_DEPTH. The sum is computed CNT_W+1 bits wide. A grant pushes `dma_dat`.
  - No grant in the cycle `dma_ack` is high, so a stale request cannot be taken twice. Maximum DMA rate is 1 byte per 2 cycles.
  - Simultaneous `host_we` and `dma_req`: host wins; the DMA request stays pending and is granted on the next eligible cycle.
- Status:
  - `thre` <= (`tf_count` == 0) & ~`tf_push` & ~(grant or `host_we` this cycle).
  - `temt` <= the same term & (`tx_state` == 0).
  - `thre_int` <= rising edge of `thre`.
  - `tx_stalled` <= `cts_hold` & (`tx_state` == 0) & (`tf_count` != 0).

## Timing
- All outputs are registered. Reset values: `enable`=0, `tf_push`=0, `tf_dat`=0, `dma_ack`=0, `thre`=1, `temt`=1, `thre_int`=0, `tx_stalled`=0, `bc`=0.
- Write latency:
  - `host_we` at cycle N -> `tf_push`=1, `tf_dat`=`host_dat` at N+1.
  - DMA grant at N -> `tf_push`, `tf_dat`, `dma_ack` all high at N+1.
- The DMA source must drop `dma_req`, or present the next byte, in the cycle after `dma_ack`.
- Baud: with `dl`=D>0, `enable` pulses every D cycles. The first pulse comes D cycles after the `dl_we` cycle plus 1 cycle of output register.
- CTS: a change on `cts_n` affects `enable` gating 3 cycles later (2 sync flops + output register).
- Reset mid-operation: all state clears asynchronously. A pending DMA request is re-arbitrated after reset release. No `dma_ack` is lost or duplicated.

## Test plan
- `dl`=4 written -> `enable` pulses every 4 cycles. Then `dl`=0 -> no pulses. Then `dl`=1 -> pulse every cycle.
- `host_we` and `dma_req` both high at cycle N -> host byte pushed at N+1, DMA byte pushed with `dma_ack` at N+2 or later, never both in one cycle.
- `tf_count`=15, `tf_push`=1, `dma_req`=1 -> no grant. After `tf_count` reaches 15 with `tf_push`=0 -> one grant, then blocked at 16.
- `afe`=1, `cts_n`=1, `tx_state`=0, `tf_count`=3 -> `enable` stays 0 and `tx_stalled`=1. `cts_n`->0 -> ticks resume after 3 cycles and `tx_stalled` clears.
- `cts_n` deasserts while `tx_state`=2 -> ticks continue to character end, then stop once `tx_state`=0.
- FIFO drains to 0 with the transmitter still active -> `thre` rises with a 1-cycle `thre_int` pulse; `temt` rises only when `tx_state`=0.
